// File: rtl/fetch_queue_frontend.sv
// Instruction-fetch front end: owns the fetch PC, issues one imem request per cycle and
// buffers {instr, pc} in a DEPTH-entry FIFO. Define FETCH_BYPASS_EN to let a response skip an empty FIFO.
module fetch_queue_frontend #(
  parameter int PC_W     = 9,
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable_debug,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_rdata,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [XLEN-1:0]            id_instr,
  output logic [PC_W-1:0]            id_pc,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tag_pc_q, tag_pc_d;
  logic            inflight_q, inflight_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] mem_instr_q [DEPTH];
  logic [XLEN-1:0] mem_instr_d [DEPTH];
  logic [PC_W-1:0] mem_pc_q [DEPTH];
  logic [PC_W-1:0] mem_pc_d [DEPTH];
  logic [XLEN-1:0] last_instr_q, last_instr_d;
  logic [PC_W-1:0] last_pc_q, last_pc_d;

  logic            fifo_empty;
  logic            live_rsp;
  logic            bypass;
  logic            pop;
  logic            pop_fifo;
  logic            push;
  logic [CW:0]     occ;

  assign fifo_empty = (count_q == '0);
  // A response is killed by a redirect and parked (not consumed) during freeze.
  assign live_rsp   = inflight_q & ~redirect_valid & ~enable_debug;

`ifdef FETCH_BYPASS_EN
  assign bypass = live_rsp & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    id_valid = 1'b0;
    id_instr = last_instr_q;
    id_pc    = last_pc_q;
    if (!fifo_empty) begin
      id_valid = 1'b1;
      id_instr = mem_instr_q[rd_ptr_q];
      id_pc    = mem_pc_q[rd_ptr_q];
    end else if (bypass) begin
      id_valid = 1'b1;
      id_instr = imem_rdata;
      id_pc    = tag_pc_q;
    end
  end

  assign pop       = id_valid & id_ready;
  assign pop_fifo  = pop & ~fifo_empty & ~redirect_valid & ~enable_debug;
  assign push      = live_rsp & ~(bypass & id_ready);
  assign occ       = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign imem_req  = ~enable_debug & ~reset & ~redirect_valid & (occ < DEPTH_C);
  assign imem_addr = pc_q;
  assign q_count   = count_q;

  always_comb begin
    pc_d         = pc_q;
    tag_pc_d     = tag_pc_q;
    inflight_d   = inflight_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    mem_instr_d  = mem_instr_q;
    mem_pc_d     = mem_pc_q;
    last_instr_d = last_instr_q;
    last_pc_d    = last_pc_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else if (!enable_debug) begin
      inflight_d = imem_req;
      if (imem_req) begin
        tag_pc_d = pc_q;
        pc_d     = pc_q + PC_W'(4);
      end
      if (push) begin
        mem_instr_d[wr_ptr_q] = imem_rdata;
        mem_pc_d[wr_ptr_q]    = tag_pc_q;
        wr_ptr_d              = wr_ptr_q + AW'(1);
      end
      if (pop_fifo) begin
        last_instr_d = mem_instr_q[rd_ptr_q];
        last_pc_d    = mem_pc_q[rd_ptr_q];
        rd_ptr_d     = rd_ptr_q + AW'(1);
      end else if (bypass && id_ready) begin
        last_instr_d = imem_rdata;
        last_pc_d    = tag_pc_q;
      end
      count_d = count_q + CW'(push) - CW'(pop_fifo);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= PC_W'(RESET_PC);
      tag_pc_q     <= '0;
      inflight_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      last_instr_q <= '0;
      last_pc_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      tag_pc_q     <= tag_pc_d;
      inflight_q   <= inflight_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      last_instr_q <= last_instr_d;
      last_pc_q    <= last_pc_d;
      mem_instr_q  <= mem_instr_d;
      mem_pc_q     <= mem_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue_frontend.sv
// Directed bench for fetch_queue_frontend: stimulus pushes expected {pc, instr} entries,
// a negedge monitor pops and compares every accepted id_* transfer.
module tb_fetch_queue_frontend;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_debug;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [8:0]  id_pc;
  logic [2:0]  q_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [8:0]  pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  fetch_queue_frontend #(.PC_W(9), .XLEN(32), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .enable_debug(enable_debug),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .q_count(q_count)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: output updates only on a request.
  always @(posedge clk)
    if (imem_req) imem_rdata <= {16'hC0DE, 7'b0, imem_addr};

  task automatic push_exp(input logic [8:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = {16'hC0DE, 7'b0, pc};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected entries never delivered, required 0", name, exp_q.size());
    end
  endtask

  task automatic do_reset(input string name);
    reset          = 1'b1;
    id_ready       = 1'b0;
    enable_debug   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step();
    exp_q.delete();
    chk({name, "_imem_req"}, 32'(imem_req), 32'd0);
    chk({name, "_q_count"},  32'(q_count),  32'd0);
    chk({name, "_id_valid"}, 32'(id_valid), 32'd0);
    chk({name, "_id_pc"},    32'(id_pc),    32'd0);
    chk({name, "_id_instr"}, id_instr,      32'd0);
    chk({name, "_imem_addr"}, 32'(imem_addr), 32'd0);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && !enable_debug && !redirect_valid && id_valid && id_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got id_pc=%h id_instr=%h, required no entry", id_pc, id_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (id_pc !== e.pc || id_instr !== e.instr) begin
          n_fail++;
          $display("FAIL pop_entry: got pc=%h instr=%h required pc=%h instr=%h",
                   id_pc, id_instr, e.pc, e.instr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Streaming with decode always ready
    do_reset("rst0");
    for (int i = 0; i < 8 - LAT; i++) push_exp(9'(4 * i));
    id_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == LAT) begin
        chk("t1_first_valid", 32'(id_valid), 32'd1);
        chk("t1_first_pc", 32'(id_pc), 32'd0);
      end
      chk("t1_qcount_le1", 32'(q_count <= 3'd1), 32'd1);
      step();
    end
    id_ready = 1'b0;
    check_drained("t1_drain");

    // Decode stalled: FIFO fills, fetch stops, release drains in order
    do_reset("rst1");
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("t2_imem_req", 32'(imem_req), (c < 4) ? 32'd1 : 32'd0);
      if (c >= 5) chk("t2_full", 32'(q_count), 32'd4);
      step();
    end
    for (int i = 0; i < 5; i++) push_exp(9'(4 * i));
    id_ready = 1'b1;
    @(negedge clk);
    chk("t2_resume_addr", 32'(imem_addr), 32'h10);
    chk("t2_resume_req", 32'(imem_req), 32'd1);
    for (int c = 0; c < 5; c++) step();
    id_ready = 1'b0;
    check_drained("t2_drain");

    // Redirect with full FIFO and a response in flight
    do_reset("rst2");
    for (int c = 0; c < 5; c++) step();
    push_exp(9'h000);
    id_ready = 1'b1;
    @(negedge clk);
    chk("t3_full", 32'(q_count), 32'd4);
    step();
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 9'h040;
    @(negedge clk);
    chk("t3_R_req", 32'(imem_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    push_exp(9'h040);
    push_exp(9'h044);
    @(negedge clk);
    chk("t3_R1_qcount", 32'(q_count), 32'd0);
    chk("t3_R1_addr", 32'(imem_addr), 32'h40);
    chk("t3_R1_req", 32'(imem_req), 32'd1);
    chk("t3_R1_valid", 32'(id_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t3_R2_valid", 32'(id_valid), (LAT == 1) ? 32'd1 : 32'd0);
    step();
    id_ready = 1'b1;
    @(negedge clk);
    chk("t3_R3_valid", 32'(id_valid), 32'd1);
    chk("t3_R3_pc", 32'(id_pc), 32'h40);
    step();
    step();
    id_ready = 1'b0;
    check_drained("t3_drain");

    // Back-to-back redirects, last one wins; PC wraps at 2^9
    do_reset("rst3");
    redirect_valid = 1'b1;
    redirect_pc    = 9'h080;
    step();
    redirect_pc    = 9'h1FC;
    @(negedge clk);
    chk("t4_R_req", 32'(imem_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    push_exp(9'h1FC);
    push_exp(9'h000);
    @(negedge clk);
    chk("t4_addr_1fc", 32'(imem_addr), 32'h1FC);
    step();
    @(negedge clk);
    chk("t4_addr_wrap", 32'(imem_addr), 32'h000);
    step();
    id_ready = 1'b1;
    step();
    step();
    id_ready = 1'b0;
    check_drained("t4_drain");

    // Freeze for 5 cycles mid-stream
    do_reset("rst4");
    for (int i = 0; i < 6 + ((LAT == 1) ? 1 : 0); i++) push_exp(9'(4 * i));
    id_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    enable_debug = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_frz_req", 32'(imem_req), 32'd0);
      chk("t5_frz_addr", 32'(imem_addr), 32'h10);
      chk("t5_frz_pc", 32'(id_pc), 32'h8);
      chk("t5_frz_valid", 32'(id_valid), (LAT == 1) ? 32'd0 : 32'd1);
      chk("t5_frz_qcount", 32'(q_count), (LAT == 1) ? 32'd0 : 32'd1);
      step();
    end
    enable_debug = 1'b0;
    for (int c = 0; c < 4; c++) step();
    id_ready = 1'b0;
    check_drained("t5_drain");

    // Reset with FIFO half full and a request in flight
    do_reset("rst5");
    for (int c = 0; c < 3; c++) step();
    @(negedge clk);
    chk("t6_half", 32'(q_count), 32'd2);
    do_reset("t6_midreset");
    for (int i = 0; i < 4 - LAT; i++) push_exp(9'(4 * i));
    id_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    id_ready = 1'b0;
    check_drained("t6_drain");

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
